prog_counter: RTL and testbench

//   Program counter / fetch-address generator. Drives ADDR of the instruction ROM,

---
 rtl/prog_counter.sv | 93 +++++++++
 tb/tb_prog_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Program counter / fetch-address generator with increment, jump, relative
// branch and CALL/RET through a small return-address stack.
module prog_counter #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned SPW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld,
  input  logic              br,
  input  logic              call,
  input  logic              ret,
  input  logic [AWIDTH-1:0] target,
  input  logic [AWIDTH-1:0] offset,
  output logic [AWIDTH-1:0] addr,
  output logic [SPW-1:0]    sp,
  output logic              stk_ovf,
  output logic              stk_unf
);

  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AWIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [SPW-1:0]    sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic [IDXW-1:0]   push_idx, pop_idx;
  logic [AWIDTH-1:0] stack_q [DEPTH];

  assign addr_inc = addr_q + AWIDTH'(1);
  assign push_idx = IDXW'(sp_q);
  assign pop_idx  = IDXW'(sp_q - SPW'(1));

  // Priority: RET > CALL > LD > BR > increment. A rejected CALL/RET falls
  // through to a plain increment.
  always_comb begin
    addr_d = addr_inc;
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push   = 1'b0;
    if (ret) begin
      if (sp_q != '0) begin
        addr_d = stack_q[pop_idx];
        sp_d   = sp_q - SPW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (call) begin
      if (sp_q < SPW'(DEPTH)) begin
        push   = 1'b1;
        sp_d   = sp_q + SPW'(1);
        addr_d = target;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ld) begin
      addr_d = target;
    end else if (br) begin
      addr_d = addr_q + offset;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (en) begin
      addr_q <= addr_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Stack storage needs no reset; SP alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (en && push) begin
      stack_q[push_idx] <= addr_inc;
    end
  end

  assign addr    = addr_q;
  assign sp      = sp_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: stimulus pushes expected state, a monitor
// pops and compares after every clock edge and after the async reset pulse.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, ld = 1'b0, br = 1'b0, call = 1'b0, ret = 1'b0;
  logic [3:0] target = '0, offset = '0;
  logic [3:0] addr;
  logic [2:0] sp;
  logic       stk_ovf, stk_unf;

  typedef struct packed {
    logic [3:0] addr;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  prog_counter #(.AWIDTH(4), .DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ld      (ld),
    .br      (br),
    .call    (call),
    .ret     (ret),
    .target  (target),
    .offset  (offset),
    .addr    (addr),
    .sp      (sp),
    .stk_ovf (stk_ovf),
    .stk_unf (stk_unf)
  );

  always #5 clk = ~clk;

  // Monitor: outputs become visible after a clock edge or a reset assertion.
  initial begin
    forever begin
      exp_t  e;
      exp_t  got;
      string nm;
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = '{addr: addr, sp: sp, ovf: stk_ovf, unf: stk_unf};
        n_total++;
        if (got === e) n_pass++;
        else $display("FAIL %s: got addr=%0d sp=%0d ovf=%b unf=%b, want addr=%0d sp=%0d ovf=%b unf=%b",
                      nm, got.addr, got.sp, got.ovf, got.unf, e.addr, e.sp, e.ovf, e.unf);
      end
    end
  end

  task automatic step(input logic e_en, input logic e_ld, input logic e_br,
                      input logic e_call, input logic e_ret,
                      input logic [3:0] t, input logic [3:0] o,
                      input logic [3:0] xa, input logic [2:0] xs,
                      input logic xo, input logic xu, input string nm);
    @(negedge clk);
    en = e_en; ld = e_ld; br = e_br; call = e_call; ret = e_ret;
    target = t; offset = o;
    exp_q.push_back('{addr: xa, sp: xs, ovf: xo, unf: xu});
    name_q.push_back(nm);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Free-running increment with wrap 15 -> 0
    for (int i = 1; i <= 17; i++)
      step(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'(i), 3'd0, 0, 0, $sformatf("inc%0d", i));
    // Stall: commands must be ignored
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 0, 4'd7, 4'd0, 4'd1, 3'd0, 0, 0, $sformatf("hold%0d", i));

    step(1, 0, 0, 0, 0, 4'd0, 4'd0,  4'd2,  3'd0, 0, 0, "to2");
    step(1, 0, 1, 0, 0, 4'd0, 4'd13, 4'd15, 3'd0, 0, 0, "br_neg3");
    step(1, 1, 0, 0, 0, 4'd9, 4'd0,  4'd9,  3'd0, 0, 0, "ld9");
    step(1, 1, 1, 0, 0, 4'd2, 4'd1,  4'd2,  3'd0, 0, 0, "ld_over_br");
    step(1, 0, 1, 0, 0, 4'd0, 4'd0,  4'd2,  3'd0, 0, 0, "br_zero");
    step(1, 1, 0, 0, 0, 4'd1, 4'd0,  4'd1,  3'd0, 0, 0, "ld1");

    // Fill the stack: returns 2, 9, 11, 13
    step(1, 0, 0, 1, 0, 4'd8,  4'd0, 4'd8,  3'd1, 0, 0, "call8");
    step(1, 0, 0, 1, 0, 4'd10, 4'd0, 4'd10, 3'd2, 0, 0, "call10");
    step(1, 0, 0, 1, 0, 4'd12, 4'd0, 4'd12, 3'd3, 0, 0, "call12");
    step(1, 0, 0, 1, 0, 4'd14, 4'd0, 4'd14, 3'd4, 0, 0, "call14");
    step(1, 0, 0, 1, 0, 4'd3,  4'd0, 4'd15, 3'd4, 1, 0, "call_ovf");
    step(0, 0, 0, 0, 1, 4'd0,  4'd0, 4'd15, 3'd4, 1, 0, "ret_stalled");

    step(1, 0, 0, 0, 1, 4'd0, 4'd0, 4'd13, 3'd3, 1, 0, "ret13");
    step(1, 0, 0, 0, 1, 4'd0, 4'd0, 4'd11, 3'd2, 1, 0, "ret11");
    step(1, 0, 0, 0, 1, 4'd0, 4'd0, 4'd9,  3'd1, 1, 0, "ret9");
    step(1, 0, 0, 0, 1, 4'd0, 4'd0, 4'd2,  3'd0, 1, 0, "ret2");
    step(1, 0, 0, 0, 1, 4'd0, 4'd0, 4'd3,  3'd0, 1, 1, "ret_unf");

    // RET beats CALL and LD; a following RET proves nothing was pushed
    step(1, 0, 0, 1, 0, 4'd6,  4'd0, 4'd6, 3'd1, 1, 1, "call6");
    step(1, 1, 0, 1, 1, 4'd12, 4'd0, 4'd4, 3'd0, 1, 1, "ret_wins");
    step(1, 0, 0, 0, 1, 4'd0,  4'd0, 4'd5, 3'd0, 1, 1, "ret_empty");

    // Async reset pulse mid clock-low
    @(negedge clk);
    en = 1'b0; ld = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0;
    exp_q.push_back('{addr: 4'd0, sp: 3'd0, ovf: 1'b0, unf: 1'b0});
    name_q.push_back("async_rst");
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    step(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd1, 3'd0, 0, 0, "post_rst_inc");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
